// File: rtl/sound_event_arbiter.sv
// sound_event_arbiter: shares the single audio PWM channel among four sound
// requesters (explosion, score, fire1, fire2). Request edges are captured
// into a pending set and granted by fixed priority. An explosion preempts any
// other sound. The granted sound steps sample_addr once per 8 kHz tick, and a
// silent gap follows each sound.
// Optional build macro SND_ARB_RR_EN: fire1/fire2 share priority below score
// and alternate via a last_fire register. Without it, fire1 beats fire2.
module sound_event_arbiter #(
  parameter int PLAY_TICKS = 4000,
  parameter int EXPL_TICKS = 8000,
  parameter int GAP_TICKS  = 80,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick8Khz,
  input  logic [3:0]        req,
  input  logic              mute,
  output logic              active,
  output logic [1:0]        sound_id,
  output logic [3:0]        grant,
  output logic [ADDR_W-1:0] sample_addr,
  output logic              sample_valid,
  output logic [3:0]        pending
);

  // A zero-length gap would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [ADDR_W-1:0] PLAY_LAST = ADDR_W'(PLAY_TICKS - 1);
  localparam logic [ADDR_W-1:0] EXPL_LAST = ADDR_W'(EXPL_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0]  GAP_SAT   = CNT_W'(GAP_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [3:0]        req_q;
  logic [3:0]        pending_d;
  logic [3:0]        pending_clr;
  logic [3:0]        edge_set;
  logic [1:0]        sound_id_d;
  logic [1:0]        sel;
  logic [3:0]        grant_d;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  gap_cnt, gap_cnt_d;
  logic              last_sample;
  logic              preempt;

`ifdef SND_ARB_RR_EN
  logic last_fire, last_fire_d;

  // Explosion, then score, then whichever fire bit was not served last.
  function automatic logic [1:0] pick_sound(input logic [3:0] p, input logic lf);
    if (p[3])             return 2'd3;
    else if (p[2])        return 2'd2;
    else if (p[1] & p[0]) return lf ? 2'd0 : 2'd1;
    else if (p[1])        return 2'd1;
    else                  return 2'd0;
  endfunction

  assign sel = pick_sound(pending, last_fire);
`else
  // Strict priority: explosion > score > fire1 > fire2.
  function automatic logic [1:0] pick_sound(input logic [3:0] p);
    if (p[3])      return 2'd3;
    else if (p[2]) return 2'd2;
    else if (p[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign sel = pick_sound(pending);
`endif

  assign edge_set     = req & ~req_q;
  assign last_sample  = (sound_id == 2'd3) ? (sample_addr == EXPL_LAST)
                                           : (sample_addr == PLAY_LAST);
  assign preempt      = (state != IDLE) && pending[3] && (sound_id != 2'd3);
  assign active       = (state == PLAY);
  assign sample_valid = (state == PLAY) && tick8Khz && !mute;

  // Next-state, grant selection, address stepping and gap counting.
  always_comb begin
    state_d     = state;
    sound_id_d  = sound_id;
    grant_d     = 4'b0000;
    addr_d      = sample_addr;
    gap_cnt_d   = gap_cnt;
    pending_clr = 4'b0000;
`ifdef SND_ARB_RR_EN
    last_fire_d = last_fire;
`endif
    if (preempt) begin
      state_d     = PLAY;
      sound_id_d  = 2'd3;
      grant_d     = 4'b1000;
      pending_clr = 4'b1000;
      addr_d      = '0;
      gap_cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != 4'b0000) begin
            state_d     = PLAY;
            sound_id_d  = sel;
            grant_d     = 4'b0001 << sel;
            pending_clr = 4'b0001 << sel;
            addr_d      = '0;
            gap_cnt_d   = '0;
`ifdef SND_ARB_RR_EN
            if (!sel[1]) last_fire_d = sel[0];
`endif
          end
        end
        PLAY: begin
          if (tick8Khz) begin
            if (last_sample) begin
              addr_d    = '0;
              gap_cnt_d = '0;
              state_d   = (GAP_TICKS == 0) ? IDLE : GAP;
            end else begin
              addr_d = sample_addr + ADDR_W'(1);
            end
          end
        end
        GAP: begin
          if (tick8Khz) begin
            if (gap_cnt == GAP_LAST) begin
              state_d   = IDLE;
              gap_cnt_d = '0;
            end else if (gap_cnt != GAP_SAT) begin
              gap_cnt_d = gap_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    // A new edge on a bit being granted this cycle survives.
    pending_d = (pending & ~pending_clr) | edge_set;
  end

  // State and control registers; reset aborts the sound and drops requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_q       <= 4'b0000;
      pending     <= 4'b0000;
      sound_id    <= 2'd0;
      grant       <= 4'b0000;
      sample_addr <= '0;
      gap_cnt     <= '0;
`ifdef SND_ARB_RR_EN
      last_fire   <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      req_q       <= req;
      pending     <= pending_d;
      sound_id    <= sound_id_d;
      grant       <= grant_d;
      sample_addr <= addr_d;
      gap_cnt     <= gap_cnt_d;
`ifdef SND_ARB_RR_EN
      last_fire   <= last_fire_d;
`endif
    end
  end

endmodule

// File: doc/sound_event_arbiter.md
Name: sound_event_arbiter

Overview:
- Shares the single 8-bit audio PWM channel among four sound requesters: explosion, score change, player-1 fire and player-2 fire.
- Captures request edges and grants the channel by priority. The explosion request preempts any other sound.
- For the granted sound it steps a sample address once per 8 kHz tick and flags each valid sample. Downstream sample ROMs and the PWM path consume these outputs.
- Sits between the keyboard/game-screen event outputs and the audio sample/PWM path, in the clk domain.

Parameters:
- PLAY_TICKS, 4000: length of score and fire sounds in 8 kHz ticks (0.5 s).
- EXPL_TICKS, 8000: length of the explosion sound in 8 kHz ticks (1.0 s).
- GAP_TICKS, 80: silent ticks inserted after each sound; 0 means no gap.
- ADDR_W, 13: sample_addr width; must satisfy 2^ADDR_W >= max(PLAY_TICKS, EXPL_TICKS).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- tick8Khz  in  1  one-clk enable pulse at 8 kHz.
- req  in  4  level requests; bit3 explosion, bit2 score, bit1 fire1, bit0 fire2.
- mute  in  1  suppresses sample_valid; timing continues.
- active  out  1  high in PLAY.
- sound_id  out  2  index of the sound currently granted/playing.
- grant  out  4  one-hot, one-clk pulse when a sound starts.
- sample_addr  out  ADDR_W  current sample index of the playing sound.
- sample_valid  out  1  one-clk pulse per tick in PLAY, qualified by !mute.
- pending  out  4  captured requests not yet served (debug/LED).

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high. All registers update on posedge clk.
- Reset: state=IDLE, active=0, sound_id=0, grant=0, sample_addr=0, sample_valid=0, pending=0, req history=0, tick counter=0.
- Reset mid-operation: every register returns to its reset value on the next edge. Sound is aborted and pending requests are discarded.
- Request capture: req_q holds the previous cycle's req.
  - pending[i] is set on a rising edge (req[i] & ~req_q[i]). A held level does not retrigger.
  - req high at reset release counts as an edge.
  - A bit is cleared only when its sound is granted. If a set and a clear hit the same bit in the same cycle, the set wins.
- Priority: fixed, bit3 > bit2 > bit1 > bit0.
- IDLE: if pending != 0, the next edge grants the highest-priority pending index i:
  - state=PLAY, sound_id=i, grant=1<<i for that single cycle;
  - pending[i] cleared, sample_addr=0, active=1.
- PLAY:
  - On each tick8Khz cycle, sample_valid=~mute and sample_addr keeps its value during that cycle; sample_addr increments on the following edge.
  - When tick8Khz arrives with sample_addr == LEN-1 (LEN=EXPL_TICKS if sound_id==3, else PLAY_TICKS), that sample is still emitted.
  - On the next edge: active=0, sample_addr=0, and the sound counts as ended.
  - After the sound ends, state goes to GAP; if GAP_TICKS==0, it goes directly to IDLE.
- GAP: counts GAP_TICKS ticks, then returns to IDLE. Pending requests wait for IDLE.
- Preemption: while in PLAY or GAP with sound_id != 3, if pending[3]=1, the next edge:
  - restarts PLAY with sound_id=3, grant=4'b1000, sample_addr=0;
  - clears pending[3].
  - The preempted sound is dropped, not resumed.
  - An explosion request during an explosion is held pending and served after the gap.
- Simultaneous requests: all are captured. They are served one per cycle of IDLE entry, in priority order, each after the previous sound and gap.
- Latency: request edge at cycle N (IDLE, nothing else pending) sets pending at N+1; grant/active assert at N+2.
- Widths: the tick counter is $clog2(GAP_TICKS+1) bits and saturates at its terminal count. Comparisons are unsigned, and sample_addr never exceeds LEN-1.

Optional Feature:
- SND_ARB_RR_EN defined: fire1 and fire2 share equal priority below score, with round-robin selection.
  - A 1-bit last_fire register (reset 0 = fire2 last served) selects the other fire bit when both are pending.
  - last_fire updates on each fire grant.
- Undefined: fixed priority fire1 > fire2, and no last_fire register exists.

Test Plan:
- Reset, then pulse req=4'b0010 for 1 clk (GAP_TICKS=80):
  - grant=4'b0010 two cycles later; 4000 sample_valid pulses with addr 0..3999;
  - active falls after the 4000th; no grant for 80 ticks.
- req=4'b0011 rising together:
  - grant fire1 first; fire2 granted on the first IDLE cycle after sound and gap (with SND_ARB_RR_EN, the first grant is fire1 since last_fire=0).
- Fire playing at sample_addr=1200, pulse req[3]:
  - grant=4'b1000 two cycles later, sample_addr=0, sound_id=3;
  - 8000 samples follow; fire is not resumed.
- Hold req[2] high for 20000 ticks:
  - exactly one score sound plays; no retrigger.
- mute=1 during PLAY:
  - sample_valid stays 0; sample_addr still advances per tick and the sound ends at the same cycle as when unmuted.
- Assert reset at sample_addr=500 with pending=4'b0101:
  - the next cycle shows all outputs 0, pending=0, state IDLE.
